// File: rtl/byte_deser_64b_rev.sv
// byte_deser_64b_rev: byte-serial to word deserializer with selectable byte order
//   clk, reset           : clock, synchronous active-high reset
//   in_, in_val, in_rdy  : byte input stream
//   rev                  : byte order of the word, taken with its first byte
//   out, out_val, out_rdy: assembled word output stream
module byte_deser_64b_rev #(
  parameter int p_nbytes = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_,
  input  logic                  in_val,
  output logic                  in_rdy,
  input  logic                  rev,
  output logic [8*p_nbytes-1:0] out,
  output logic                  out_val,
  input  logic                  out_rdy
);
  localparam int cw = $clog2(p_nbytes);
  typedef enum logic {RECV, SEND} state_t;
  state_t state, state_n;
  logic [cw-1:0] cnt, idx;
  logic rev_q, rev_eff, in_xfer, last;
  always_comb begin
    in_rdy = !reset && state == RECV;
    out_val = !reset && state == SEND;
    in_xfer = in_val && in_rdy;
    last = cnt == cw'(p_nbytes - 1);
    rev_eff = (cnt == '0) ? rev : rev_q;
    idx = rev_eff ? cw'(p_nbytes - 1) - cnt : cnt;
    state_n = (in_xfer && last) ? SEND : (out_val && out_rdy) ? RECV : state;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= RECV;
      cnt <= '0;
      rev_q <= 1'b0;
      out <= '0;
    end else begin
      state <= state_n;
      if (in_xfer) begin
        if (cnt == '0) rev_q <= rev;
        out[{idx, 3'b000} +: 8] <= in_;
        cnt <= last ? '0 : cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_byte_deser_64b_rev.sv
// tb_byte_deser_64b_rev: self-checking bench for byte_deser_64b_rev
module tb_byte_deser_64b_rev;
  logic clk = 1'b0;
  logic reset, in_val, in_rdy, rev, out_val, out_rdy;
  logic [7:0] in_;
  logic [63:0] out;
  int ncmp = 0;
  int nerr = 0;
  logic [7:0] q[$];
  logic wrev = 1'b0;
  logic pend = 1'b0;
  logic [63:0] exp_word = '0;
  logic [63:0] o;
  logic ov, ir;
  typedef struct {
    logic rv;
    logic [63:0] bytes;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl[4];
  logic [63:0] got[4];
  byte_deser_64b_rev #(.p_nbytes(8)) dut (
    .clk(clk), .reset(reset), .in_(in_), .in_val(in_val), .in_rdy(in_rdy),
    .rev(rev), .out(out), .out_val(out_val), .out_rdy(out_rdy)
  );
  always #5 clk = ~clk;
  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    ncmp++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endfunction
  function automatic logic [63:0] assemble();
    logic [63:0] w = '0;
    foreach (q[i]) w = w | (64'(q[i]) << (8 * i));
    return wrev ? {<<8{w}} : w;
  endfunction
  task automatic cyc(input logic r, input logic v, input logic [7:0] b, input logic rv, input logic ordy);
    reset = r;
    in_val = v;
    in_ = b;
    rev = rv;
    out_rdy = ordy;
    @(negedge clk);
    o = out;
    ov = out_val;
    ir = in_rdy;
    chk("in_rdy", {63'd0, ir}, {63'd0, !r && !pend});
    chk("out_val", {63'd0, ov}, {63'd0, !r && pend});
    if (!r && pend) chk("out", o, exp_word);
    if (r) begin
      pend = 1'b0;
      q.delete();
    end else if (pend) begin
      if (ordy) pend = 1'b0;
    end else if (v) begin
      if (q.size() == 0) wrev = rv;
      q.push_back(b);
      if (q.size() == 8) begin
        exp_word = assemble();
        pend = 1'b1;
        q.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic feed(input logic rv, input logic [63:0] bytes, input logic ordy);
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1, bytes[8*k +: 8], rv, ordy);
  endtask
  initial begin
    int bubbles, cycles;
    tbl[0] = '{1'b0, 64'h0807060504030201, 64'h0807060504030201};
    tbl[1] = '{1'b1, 64'h0807060504030201, 64'h0102030405060708};
    tbl[2] = '{1'b0, 64'h78563412EFBEADDE, 64'h78563412EFBEADDE};
    tbl[3] = '{1'b1, 64'h78563412EFBEADDE, 64'hDEADBEEF12345678};
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("rst_in_rdy", {63'd0, ir}, 64'd0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_out", o, 64'd0);
    chk("rst_rdy", {63'd0, ir}, 64'd1);
    for (int t = 0; t < 4; t++) begin
      feed(tbl[t].rv, tbl[t].bytes, 1'b1);
      cyc(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1);
      chk("tbl_val", {63'd0, ov}, 64'd1);
      chk("tbl_word", o, tbl[t].exp);
      got[t] = o;
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("tbl_val_1cyc", {63'd0, ov}, 64'd0);
      chk("tbl_recv", {63'd0, ir}, 64'd1);
    end
    chk("rev_eq", got[3], {<<8{got[2]}});
    feed(1'b0, 64'h0F0E0D0C0B0A0908, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
      chk("hold_word", o, 64'h0F0E0D0C0B0A0908);
    end
    cyc(1'b0, 1'b1, 8'h55, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("hold_back_recv", {63'd0, ir}, 64'd1);
    bubbles = 0;
    cycles = 0;
    for (int k = 0; k < 8; ) begin
      cycles++;
      if (k > 0 && $urandom_range(0, 2) == 0) begin
        bubbles++;
        cyc(1'b0, 1'b0, 8'hFF, 1'($urandom), 1'b0);
      end else begin
        cyc(1'b0, 1'b1, 8'h10 + 8'(k), (k == 0) ? 1'b1 : 1'(k & 1) ^ 1'b1, 1'b0);
        k++;
      end
    end
    ov = 1'b0;
    for (int n = 0; n < 20 && !ov; n++) begin
      cycles++;
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    end
    chk("tog_seen", {63'd0, ov}, 64'd1);
    chk("tog_word", o, 64'h1011121314151617);
    chk("tog_cycles", 64'(cycles), 64'(8 + bubbles + 1));
    cyc(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'hBB, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'hCC, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'hDD, 1'b0, 1'b0);
    chk("mid_rst_rdy", {63'd0, ir}, 64'd0);
    feed(1'b0, 64'h8877665544332211, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("mid_rst_word", o, 64'h8877665544332211);
    feed(1'b1, 64'hCAFEF00D01234567, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("send_pend", {63'd0, ov}, 64'd1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("send_rst_drop", {63'd0, ov}, 64'd0);
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 99) == 0), 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
